// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache miss path: FSM state encoding,
// default geometry (4 sets, 16-byte blocks) and address field positions.
// Latency: n/a (types and constants only). Backpressure: n/a.
package cache_pkg;

  localparam int BLOCK_WORDS = 4;   // words per cache block
  localparam int TAG_W       = 26;  // 32 - 6 for 4 sets of 16-byte blocks

  // Address field positions for the default geometry
  localparam int TAG_MSB   = 31;
  localparam int TAG_LSB   = 6;
  localparam int INDEX_MSB = 5;
  localparam int INDEX_LSB = 4;
  localparam int WORD_MSB  = 3;
  localparam int WORD_LSB  = 2;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    COMMIT
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[TAG_MSB:TAG_LSB];
  endfunction

  function automatic logic [INDEX_MSB-INDEX_LSB:0] addr_index(input logic [31:0] a);
    return a[INDEX_MSB:INDEX_LSB];
  endfunction

  function automatic logic [WORD_MSB-WORD_LSB:0] addr_word(input logic [31:0] a);
    return a[WORD_MSB:WORD_LSB];
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// L2 word-request bus between the miss controller (master) and L2 (slave).
// Latency: request held until l2_ack; read data valid in the ack cycle.
// Backpressure: L2 stalls a word simply by withholding l2_ack.
// Ports: l2_req/l2_we/l2_addr/l2_wdata (master->slave), l2_ack/l2_rdata (slave->master).
interface cache_miss_ctrl_if;
  logic        l2_req;
  logic        l2_we;
  logic [31:0] l2_addr;
  logic [31:0] l2_wdata;
  logic        l2_ack;
  logic [31:0] l2_rdata;

  modport master (
    output l2_req, l2_we, l2_addr, l2_wdata,
    input  l2_ack, l2_rdata
  );

  modport slave (
    input  l2_req, l2_we, l2_addr, l2_wdata,
    output l2_ack, l2_rdata
  );
endinterface

// File: rtl/cache_perf_cnt.sv
// Miss / write-back event counters for the miss controller.
// Latency: count visible the cycle after the start pulse. Backpressure: none.
// Ports: CLK, RST (sync, active-high), miss_start_i, wb_start_i, miss_cnt_o, wb_cnt_o.
module cache_perf_cnt (
  input  logic        CLK,
  input  logic        RST,
  input  logic        miss_start_i,
  input  logic        wb_start_i,
  output logic [31:0] miss_cnt_o,
  output logic [31:0] wb_cnt_o
);

  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  // Free-running wrap at 2^32
  always_comb begin
    miss_cnt_d = miss_cnt_q + {31'd0, miss_start_i};
    wb_cnt_d   = wb_cnt_q + {31'd0, wb_start_i};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Data-cache miss controller: optional victim write-back, block refill from L2, tag commit.
// Latency: clean miss BLOCK_WORDS+1 cycles, dirty 2*BLOCK_WORDS+1 (ack every cycle) after the request cycle.
// Backpressure: pipeline frozen via stall; each L2 word waits for l2_ack.
// Ports: CLK, RST (sync, active-high); pipeline side mem_req/miss/addr; victim side
//   victim_dirty/victim_tag/wb_data/word_idx; L2 bus via cache_miss_ctrl_if.master;
//   array update fill_we/fill_data/tag_we; stall.
// Option: define CACHE_PERF_CNT_EN to add miss_cnt / wb_cnt outputs.
module cache_miss_ctrl #(
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int TAG_W       = cache_pkg::TAG_W
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           mem_req,
  input  logic                           miss,
  input  logic [31:0]                    addr,
  input  logic                           victim_dirty,
  input  logic [TAG_W-1:0]               victim_tag,
  input  logic [31:0]                    wb_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_idx,
  cache_miss_ctrl_if.master              l2,
  output logic                           fill_we,
  output logic [31:0]                    fill_data,
  output logic                           tag_we,
  output logic                           stall
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]                    miss_cnt,
  output logic [31:0]                    wb_cnt
`endif
);

  import cache_pkg::*;

  localparam int WIDX_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = WIDX_W + 2;                  // byte offset within a block
  localparam int IDX_W  = INDEX_MSB - INDEX_LSB + 1;   // set index width
  localparam int LINE_W = 32 - OFF_W;                  // block-aligned address bits

  state_t             state_q;
  logic [WIDX_W-1:0]  word_idx_q;
  logic [LINE_W-1:0]  line_q;
  logic [TAG_W-1:0]   vtag_q;

  logic               start;
  logic               last_word;
  logic [31:0]        wb_addr;
  logic [31:0]        fill_addr;
  logic               unused_addr_lo;

  assign start     = (state_q == IDLE) && mem_req && miss;
  assign last_word = &word_idx_q;   // BLOCK_WORDS is a power of two
  assign unused_addr_lo = ^addr[OFF_W-1:0];

  // Write-back goes to the victim's block: victim tag with the requesting set index
  assign wb_addr   = {vtag_q, line_q[IDX_W-1:0], word_idx_q, 2'b00};
  assign fill_addr = {line_q, word_idx_q, 2'b00};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      line_q     <= '0;
      vtag_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Everything the sequence needs is captured here; inputs may wander while stalled
            line_q     <= addr[31:OFF_W];
            vtag_q     <= victim_tag;
            word_idx_q <= '0;
            state_q    <= victim_dirty ? WB : FILL;
          end
        end
        WB: begin
          if (l2.l2_ack) begin
            word_idx_q <= word_idx_q + 1'b1;   // wraps to 0 after the last word
            if (last_word) state_q <= FILL;
          end
        end
        FILL: begin
          if (l2.l2_ack) begin
            word_idx_q <= word_idx_q + 1'b1;
            if (last_word) state_q <= COMMIT;
          end
        end
        COMMIT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; only the first stall cycle and the
  // fill strobe follow inputs (mem_req/miss and l2_ack) within the cycle.
  always_comb begin
    l2.l2_req   = 1'b0;
    l2.l2_we    = 1'b0;
    l2.l2_addr  = '0;
    l2.l2_wdata = '0;
    fill_we     = 1'b0;
    fill_data   = '0;
    tag_we      = 1'b0;
    stall       = start;
    case (state_q)
      WB: begin
        l2.l2_req   = 1'b1;
        l2.l2_we    = 1'b1;
        l2.l2_addr  = wb_addr;
        l2.l2_wdata = wb_data;
        stall       = 1'b1;
      end
      FILL: begin
        l2.l2_req  = 1'b1;
        l2.l2_addr = fill_addr;
        fill_we    = l2.l2_ack;
        fill_data  = l2.l2_ack ? l2.l2_rdata : '0;
        stall      = 1'b1;
      end
      COMMIT: begin
        tag_we = 1'b1;
        stall  = 1'b1;
      end
      default: ;
    endcase
  end

  assign word_idx = word_idx_q;

`ifdef CACHE_PERF_CNT_EN
  logic wb_start;
  assign wb_start = start && victim_dirty;

  cache_perf_cnt u_perf_cnt (
    .CLK          (CLK),
    .RST          (RST),
    .miss_start_i (start),
    .wb_start_i   (wb_start),
    .miss_cnt_o   (miss_cnt),
    .wb_cnt_o     (wb_cnt)
  );
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: directed misses with a scoreboard of expected L2
// transactions and fill words, checked by an independent negedge monitor.
module tb_cache_miss_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } l2_txn_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        mem_req, miss, victim_dirty;
  logic [31:0] addr;
  logic [25:0] victim_tag;
  logic [31:0] wb_data;
  logic [1:0]  word_idx;
  logic        fill_we, tag_we, stall;
  logic [31:0] fill_data;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] miss_cnt, wb_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int tag_cnt = 0;
  int ack_period = 1;
  int ack_wait = 0;
  logic ack_raw = 1'b0;
  logic force_ack = 1'b0;

  l2_txn_t l2_q[$];
  logic [31:0] fill_q[$];
  l2_txn_t mon_t;

  cache_miss_ctrl_if l2_bus ();

  cache_miss_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .mem_req      (mem_req),
    .miss         (miss),
    .addr         (addr),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .wb_data      (wb_data),
    .word_idx     (word_idx),
    .l2           (l2_bus),
    .fill_we      (fill_we),
    .fill_data    (fill_data),
    .tag_we       (tag_we),
    .stall        (stall)
`ifdef CACHE_PERF_CNT_EN
    ,
    .miss_cnt     (miss_cnt),
    .wb_cnt       (wb_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Cache array model: victim word w reads as DA7A_000w
  assign wb_data = 32'hDA7A_0000 + {30'd0, word_idx};
  // L2 model: read data is the address scrambled with a constant
  assign l2_bus.l2_ack   = (ack_raw & ~RST) | force_ack;
  assign l2_bus.l2_rdata = l2_bus.l2_addr ^ 32'h5A5A_0000;

  // L2 acks each word after ack_period cycles of request
  always @(posedge CLK) begin
    #1;
    if (l2_bus.l2_req) begin
      if (ack_wait >= ack_period - 1) begin
        ack_raw  = 1'b1;
        ack_wait = 0;
      end else begin
        ack_raw  = 1'b0;
        ack_wait = ack_wait + 1;
      end
    end else begin
      ack_raw  = 1'b0;
      ack_wait = 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every cycle with l2_req must match the head of the expected queue
  // (so address/data stay put while L2 waits); the head retires on ack.
  always @(negedge CLK) begin
    if (l2_bus.l2_req) begin
      if (l2_q.size() == 0) begin
        check("l2_req_unexpected", 32'd1, 32'd0);
      end else begin
        mon_t = l2_q[0];
        check("l2_we", {31'd0, l2_bus.l2_we}, {31'd0, mon_t.we});
        check("l2_addr", l2_bus.l2_addr, mon_t.addr);
        if (mon_t.we) check("l2_wdata", l2_bus.l2_wdata, mon_t.wdata);
        check("word_idx", {30'd0, word_idx}, {30'd0, mon_t.addr[3:2]});
        if (l2_bus.l2_ack) void'(l2_q.pop_front());
      end
    end
    if (fill_we) begin
      if (fill_q.size() == 0) check("fill_we_unexpected", 32'd1, 32'd0);
      else check("fill_data", fill_data, fill_q.pop_front());
    end
    if (tag_we) tag_cnt = tag_cnt + 1;
  end

  task automatic push_expect(input logic [31:0] a, input logic dirty, input logic [25:0] vt);
    l2_txn_t t;
    if (dirty) begin
      for (int w = 0; w < 4; w++) begin
        t.we    = 1'b1;
        t.addr  = ({6'd0, vt} << 6) | (a & 32'h0000_0030) | 32'(w << 2);
        t.wdata = 32'hDA7A_0000 + 32'(w);
        l2_q.push_back(t);
      end
    end
    for (int w = 0; w < 4; w++) begin
      t.we    = 1'b0;
      t.addr  = (a & 32'hFFFF_FFF0) | 32'(w << 2);
      t.wdata = '0;
      l2_q.push_back(t);
      fill_q.push_back(t.addr ^ 32'h5A5A_0000);
    end
  endtask

  // One complete miss; the request cycle is stalled combinationally, then the
  // FSM stays away from IDLE for period*words + 1 cycles (the commit cycle).
  task automatic run_miss(input string nm, input logic [31:0] a, input logic dirty,
                          input logic [25:0] vt, input int period);
    int n;
    int budget;
    int tag0;
    ack_period = period;
    push_expect(a, dirty, vt);
    tag0 = tag_cnt;
    @(posedge CLK); #1;
    mem_req = 1'b1; miss = 1'b1; addr = a; victim_dirty = dirty; victim_tag = vt;
    @(negedge CLK);
    check({nm, "_stall_req_cycle"}, {31'd0, stall}, 32'd1);
    @(posedge CLK); #1;
    // Pipeline retries as a hit; scrambled inputs must not disturb the sequence
    miss = 1'b0; addr = 32'hFFFF_FFF0; victim_tag = '1; victim_dirty = ~dirty;
    n = 0;
    budget = 0;
    @(negedge CLK);
    while (stall === 1'b1 && budget < 200) begin
      n++;
      budget++;
      @(negedge CLK);
    end
    if (budget >= 200) check({nm, "_timeout"}, 32'd1, 32'd0);
    check({nm, "_stall_cycles"}, 32'(n), 32'(period * (dirty ? 8 : 4) + 1));
    check({nm, "_tag_we_pulses"}, 32'(tag_cnt - tag0), 32'd1);
    check({nm, "_queue_left"}, 32'(l2_q.size() + fill_q.size()), 32'd0);
    @(posedge CLK); #1;
    mem_req = 1'b0;
  endtask

  initial begin
    int tag0;
    RST = 1'b1; mem_req = 1'b0; miss = 1'b0; addr = '0; victim_dirty = 1'b0; victim_tag = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_l2_req", {31'd0, l2_bus.l2_req}, 32'd0);
    check("rst_l2_we", {31'd0, l2_bus.l2_we}, 32'd0);
    check("rst_l2_addr", l2_bus.l2_addr, 32'd0);
    check("rst_fill_we", {31'd0, fill_we}, 32'd0);
    check("rst_tag_we", {31'd0, tag_we}, 32'd0);
    check("rst_word_idx", {30'd0, word_idx}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Hit, then miss without mem_req, with stray acks that must be ignored
    mem_req = 1'b1; miss = 1'b0; addr = 32'h0000_1230; force_ack = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("hit_stall", {31'd0, stall}, 32'd0);
      check("hit_l2_req", {31'd0, l2_bus.l2_req}, 32'd0);
    end
    @(posedge CLK); #1;
    mem_req = 1'b0; miss = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("nomem_stall", {31'd0, stall}, 32'd0);
      check("nomem_l2_req", {31'd0, l2_bus.l2_req}, 32'd0);
    end
    @(posedge CLK); #1;
    miss = 1'b0; force_ack = 1'b0;

    run_miss("clean", 32'h0000_1230, 1'b0, 26'h0, 1);
    run_miss("dirty", 32'h0000_0040, 1'b1, 26'h15, 1);
    run_miss("slow_dirty", 32'h0000_2A64, 1'b1, 26'h2ABCDE, 3);
    run_miss("slow_clean", 32'hCAFE_0018, 1'b0, 26'h3, 3);
    run_miss("clean2", 32'h8000_0000, 1'b0, 26'h1, 1);
`ifdef CACHE_PERF_CNT_EN
    check("miss_cnt", miss_cnt, 32'd5);
    check("wb_cnt", wb_cnt, 32'd2);
`endif

    // Reset after two fill words: sequence abandoned, no tag commit
    ack_period = 1;
    push_expect(32'h0000_2000, 1'b0, 26'h0);
    tag0 = tag_cnt;
    @(posedge CLK); #1;
    mem_req = 1'b1; miss = 1'b1; addr = 32'h0000_2000; victim_dirty = 1'b0;
    @(posedge CLK); #1;
    miss = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    check("rstmid_l2_req", {31'd0, l2_bus.l2_req}, 32'd0);
    check("rstmid_word_idx", {30'd0, word_idx}, 32'd0);
    check("rstmid_fill_words_left", 32'(fill_q.size()), 32'd2);
    check("rstmid_tag_we", 32'(tag_cnt - tag0), 32'd0);
    l2_q.delete();
    fill_q.delete();
    @(posedge CLK); #1;
    mem_req = 1'b0;

    run_miss("after_rst", 32'h0000_3010, 1'b0, 26'h0, 1);
`ifdef CACHE_PERF_CNT_EN
    check("miss_cnt_after_rst", miss_cnt, 32'd1);
    check("wb_cnt_after_rst", wb_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
